// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI mode-0 target: default idle byte, FSM states, bit-count width.
package spi_target_pkg;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;
  localparam int         CNT_W         = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer plus edge-detect register for one asynchronous SPI pin.
// Strobes are registered single clk7 pulses, suppressed until the pipeline holds real history.
module spi_target_sync (
  input  logic clk7,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;     // [0],[1] synchronizer, [2] edge-detect history
  logic [1:0] prime;  // counts stages filled since reset
  logic       armed;

  assign armed = (prime == 2'd3);

  // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
  always_ff @(posedge clk7) begin
    if (rst) begin
      sh    <= '0;
      prime <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sh <= {sh[1:0], pin};
      if (!armed) prime <= prime + 2'd1;
      level <= sh[1];
      rise  <= armed &&  sh[1] && !sh[2];
      fall  <= armed && !sh[1] &&  sh[2];
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled on clk7, with byte-wide rx/tx handshakes.
// Optional sticky rx_overrun flag built only when SPI_TARGET_OVERRUN_EN is defined.
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic       clk7,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       _cs,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       selected
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic unused_sync;

  spi_target_sync u_sync_sclk (.clk7(clk7), .rst(rst), .pin(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_target_sync u_sync_mosi (.clk7(clk7), .rst(rst), .pin(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
  spi_target_sync u_sync_cs   (.clk7(clk7), .rst(rst), .pin(_cs),  .level(cs_lvl),   .rise(cs_rise),   .fall(cs_fall));

  assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall, cs_lvl};

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       rx_shift, tx_shift, hold;
  logic             hold_full;
  logic [7:0]       rx_next, tx_src;
  logic             byte_done;

  assign rx_next   = {rx_shift[6:0], mosi_lvl};
  assign tx_src    = hold_full ? hold : IDLE_BYTE;
  assign byte_done = (state == ST_SHIFT) && !cs_rise && sclk_rise && (&bit_cnt);

  always_ff @(posedge clk7) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_ready  <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      selected  <= 1'b0;
    end else begin
      // tx_ready trails hold_full by one cycle; a load clears it at once.
      tx_ready <= !hold_full;
      if (tx_load && tx_ready) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
        tx_ready  <= 1'b0;
      end
      if (rx_ack) rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state    <= ST_SHIFT;
            bit_cnt  <= '0;
            tx_shift <= tx_src;
            miso     <= tx_src[7];
            miso_oe  <= 1'b1;
            selected <= 1'b1;
            if (hold_full) hold_full <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            selected <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + CNT_W'(1);
              // A completing byte overrides a coincident rx_ack.
              if (byte_done) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end
            end
            if (sclk_fall) begin
              if (bit_cnt == '0) begin
                tx_shift <= tx_src;
                miso     <= tx_src[7];
                if (hold_full) hold_full <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                miso     <= tx_shift[6];
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_TARGET_OVERRUN_EN
  always_ff @(posedge clk7) begin
    if (rst)                                 rx_overrun <= 1'b0;
    else if (byte_done && rx_valid && !rx_ack) rx_overrun <= 1'b1;
  end
`else
  assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: vector table plus hand sequences for timing and corner cases.
module tb_spi_target;

  logic       clk7, rst, sclk, mosi, _cs;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_overrun, selected;
  logic       tx_load, rx_ack;
  logic [7:0] tx_data, rx_data;

  int n_cmp = 0;
  int n_bad = 0;

  spi_target dut (
    .clk7(clk7), .rst(rst), .sclk(sclk), .mosi(mosi), ._cs(_cs),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .selected(selected)
  );

  initial clk7 = 1'b0;
  always #5 clk7 = ~clk7;

  typedef struct {
    logic       do_load;
    logic       dbl_load;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

`ifdef SPI_TARGET_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk7);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic deselect();
    tick(6);
    _cs = 1'b1;
    tick(6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
  endtask

  // mode 1: check rx_valid latency, 2: check tx_ready after last fall, 3: rx_ack at completion
  task automatic spi_byte(input int nbits, input logic [7:0] mo, input int mode, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      tick(6);
      mi[7-i] = miso;
      sclk = 1'b1;
      if (i == 7 && mode == 1) begin
        tick(3);
        check("rx_valid_before_4", 8'(rx_valid), 8'h00);
        tick(1);
        check("rx_valid_at_4", 8'(rx_valid), 8'h01);
        tick(2);
      end else if (i == 7 && mode == 3) begin
        tick(3);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(2);
      end else begin
        tick(6);
      end
      sclk = 1'b0;
      if (i == 7 && mode == 2) begin
        tick(4);
        check("tx_ready_at_reload", 8'(tx_ready), 8'h00);
        tick(1);
        check("tx_ready_after_reload", 8'(tx_ready), 8'h01);
        tick(1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi;
    logic       seen;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h55, 8'hFF, 8'h55};
    vecs[1] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[2] = '{1'b1, 1'b1, 8'h3C, 8'hC0, 8'h3C, 8'hC0};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h80, 8'h01};

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; _cs = 1'b1;
    tx_load = 1'b0; rx_ack = 1'b0; tx_data = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(5);

    check("rst_miso",       8'(miso),       8'h00);
    check("rst_miso_oe",    8'(miso_oe),    8'h00);
    check("rst_tx_ready",   8'(tx_ready),   8'h01);
    check("rst_rx_data",    rx_data,        8'h00);
    check("rst_rx_valid",   8'(rx_valid),   8'h00);
    check("rst_rx_overrun", 8'(rx_overrun), 8'h00);
    check("rst_selected",   8'(selected),   8'h00);

    // sclk activity while deselected must do nothing
    mosi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1; tick(6);
      sclk = 1'b0; tick(6);
    end
    check("idle_sclk_rx_valid", 8'(rx_valid), 8'h00);
    check("idle_sclk_miso_oe",  8'(miso_oe),  8'h00);

    // select latency and rx_valid latency with A5 out / 3C in
    load(8'hA5);
    check("load_tx_ready", 8'(tx_ready), 8'h00);
    _cs = 1'b0;
    tick(3);
    check("cs_oe_before_4", 8'(miso_oe), 8'h00);
    tick(1);
    check("cs_oe_at_4",     8'(miso_oe),  8'h01);
    check("cs_msb_at_4",    8'(miso),     8'h01);
    check("cs_selected",    8'(selected), 8'h01);
    spi_byte(8, 8'h3C, 1, mi);
    deselect();
    check("a5_miso_byte", mi, 8'hA5);
    check("a5_rx_data",   rx_data, 8'h3C);
    check("a5_tx_ready",  8'(tx_ready), 8'h01);
    check("a5_oe_off",    8'(miso_oe), 8'h00);
    ack();
    check("ack_clears", 8'(rx_valid), 8'h00);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_load) begin
        load(vecs[i].tx);
        if (vecs[i].dbl_load) load(8'h77);
      end
      check($sformatf("v%0d_tx_ready_pre", i), 8'(tx_ready), 8'(!vecs[i].do_load));
      _cs = 1'b0;
      spi_byte(8, vecs[i].mo, 0, mi);
      deselect();
      check($sformatf("v%0d_miso", i),     mi,             vecs[i].exp_mi);
      check($sformatf("v%0d_rx_data", i),  rx_data,        vecs[i].exp_rx);
      check($sformatf("v%0d_rx_valid", i), 8'(rx_valid),   8'h01);
      check($sformatf("v%0d_tx_ready", i), 8'(tx_ready),   8'h01);
      ack();
    end

    // abort after 5 bits, holding register loaded mid-transfer must survive
    _cs = 1'b0;
    tick(6);
    load(8'hC3);
    spi_byte(5, 8'hF0, 0, mi);
    tick(6);
    _cs = 1'b1;
    tick(3);
    check("abort_oe_before_4", 8'(miso_oe), 8'h01);
    tick(1);
    check("abort_oe_at_4",   8'(miso_oe),  8'h00);
    check("abort_selected",  8'(selected), 8'h00);
    check("abort_rx_valid",  8'(rx_valid), 8'h00);
    check("abort_tx_ready",  8'(tx_ready), 8'h00);
    tick(4);
    _cs = 1'b0;
    spi_byte(8, 8'h96, 0, mi);
    deselect();
    check("restart_miso",     mi,           8'hC3);
    check("restart_rx_data",  rx_data,      8'h96);
    check("restart_rx_valid", 8'(rx_valid), 8'h01);
    ack();

    // back-to-back bytes, second byte loaded while the first is in flight, no rx_ack
    load(8'h5A);
    _cs = 1'b0;
    tick(6);
    check("b2b_ready_in_byte1", 8'(tx_ready), 8'h01);
    load(8'h12);
    spi_byte(8, 8'h81, 2, mi);
    check("b2b_miso_byte1", mi, 8'h5A);
    spi_byte(8, 8'h7E, 0, mi);
    check("b2b_miso_byte2", mi, 8'h12);
    deselect();
    check("b2b_rx_data",  rx_data,        8'h7E);
    check("b2b_rx_valid", 8'(rx_valid),   8'h01);
    check("b2b_overrun",  8'(rx_overrun), 8'(EXP_OVR));
    ack();

    // rx_ack coincident with completion: new byte wins, no overrun
    do_reset();
    check("reset_clears_overrun", 8'(rx_overrun), 8'h00);
    _cs = 1'b0;
    spi_byte(8, 8'h11, 0, mi);
    spi_byte(8, 8'h22, 3, mi);
    deselect();
    check("coinc_rx_valid", 8'(rx_valid),   8'h01);
    check("coinc_rx_data",  rx_data,        8'h22);
    check("coinc_overrun",  8'(rx_overrun), 8'h00);
    ack();

    // reset in the middle of a byte
    load(8'h00);
    _cs = 1'b0;
    spi_byte(3, 8'hE7, 0, mi);
    rst = 1'b1;
    tick(1);
    check("midrst_miso",     8'(miso),       8'h00);
    check("midrst_miso_oe",  8'(miso_oe),    8'h00);
    check("midrst_tx_ready", 8'(tx_ready),   8'h01);
    check("midrst_rx_data",  rx_data,        8'h00);
    check("midrst_rx_valid", 8'(rx_valid),   8'h00);
    check("midrst_selected", 8'(selected),   8'h00);
    _cs = 1'b1;
    tick(1);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | rx_valid | selected | miso_oe;
    end
    check("postrst_quiet", 8'(seen), 8'h00);
    _cs = 1'b0;
    spi_byte(8, 8'h5A, 0, mi);
    deselect();
    check("postrst_miso",    mi,      8'hFF);
    check("postrst_rx_data", rx_data, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
